// File: rtl/sub_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg -- shared definitions for the sequential slice-serial subtractor.
//
// Contents:
//   state_e          FSM state type (IDLE / CALC / DONE)
//   SUB_WIDTH        default operand / result width
//   SUB_SLICE_W      default number of bits processed per cycle
//   sub_num_slices() number of slices for a given width / slice width
// ---------------------------------------------------------------------------
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned SUB_WIDTH   = 32;
   localparam int unsigned SUB_SLICE_W = 8;

   function automatic int unsigned sub_num_slices(input int unsigned w,
                                                  input int unsigned sw);
      return w / sw;
   endfunction

endpackage

// File: rtl/sub_slice.sv
// ---------------------------------------------------------------------------
// sub_slice -- combinational W-bit subtract with borrow in / borrow out.
//
// Ports:
//   a_i    [W-1:0]  minuend slice
//   b_i    [W-1:0]  subtrahend slice
//   bin_i           borrow into this slice
//   d_o    [W-1:0]  a_i - b_i - bin_i modulo 2^W
//   bout_o          borrow out of this slice (1 when a_i < b_i + bin_i)
// ---------------------------------------------------------------------------
module sub_slice
   import sub_pkg::*;
#(
   parameter int unsigned W = SUB_SLICE_W
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         bin_i,
   output logic [W-1:0] d_o,
   output logic         bout_o
);

   logic [W:0] ext;

   // One extra bit on the left: it goes to 1 exactly when the subtraction
   // underflows, which is the borrow out.
   always_comb begin
      ext    = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, bin_i};
      d_o    = ext[W-1:0];
      bout_o = ext[W];
   end

endmodule

// File: rtl/sub_32bit_seq.sv
// ---------------------------------------------------------------------------
// sub_32bit_seq -- sequential unsigned subtractor, one SLICE_W slice per cycle.
//
// A single sub_slice instance is time-multiplexed across the operand, LSB
// slice first. Accepting an operand pair takes one edge in IDLE; the result
// appears WIDTH/SLICE_W edges later in DONE and is held until out_ready.
//
// Parameters:
//   WIDTH    operand / result width (multiple of SLICE_W)
//   SLICE_W  bits processed per cycle
//
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       synchronous active-low reset
//   in_valid    operand pair offered
//   in_ready    block idle and able to accept operands
//   a, b        minuend / subtrahend (unsigned)
//   out_valid   result available
//   out_ready   consumer takes the result
//   diff        a - b modulo 2^WIDTH (last completed value)
//   borrow_out  1 when a < b
//
// Build option:
//   SUB_SATURATE_EN  when defined, a final borrow forces diff to 0
//                    (unsigned floor); borrow_out still reports 1.
// ---------------------------------------------------------------------------
module sub_32bit_seq
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH   = SUB_WIDTH,
   parameter int unsigned SLICE_W = SUB_SLICE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned NSLICES = sub_num_slices(WIDTH, SLICE_W);
   localparam int unsigned IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

   state_e             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   res_q;
   logic [WIDTH-1:0]   res_d;
   logic [IDX_W-1:0]   idx_q;
   logic               borrow_q;
   logic [WIDTH-1:0]   diff_q;
   logic               borrow_out_q;
   logic               out_valid_q;
   logic               in_ready_q;

   logic [SLICE_W-1:0] slice_d;
   logic               slice_bout;

   // Operands are shifted right after each slice, so the active slice is
   // always the low SLICE_W bits; no variable part-select is needed.
   sub_slice #(
      .W (SLICE_W)
   ) u_slice (
      .a_i    (a_q[SLICE_W-1:0]),
      .b_i    (b_q[SLICE_W-1:0]),
      .bin_i  (borrow_q),
      .d_o    (slice_d),
      .bout_o (slice_bout)
   );

   // Partial result fills from the top: after NSLICES shifts the first
   // computed slice has arrived at the LSB position.
   always_comb begin
      res_d = (res_q >> SLICE_W) | (WIDTH'(slice_d) << (WIDTH - SLICE_W));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         idx_q        <= '0;
         borrow_q     <= 1'b0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         out_valid_q  <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  res_q      <= '0;
                  idx_q      <= '0;
                  borrow_q   <= 1'b0;
                  in_ready_q <= 1'b0;
                  state_q    <= CALC;
               end
            end

            CALC: begin
               a_q      <= a_q >> SLICE_W;
               b_q      <= b_q >> SLICE_W;
               res_q    <= res_d;
               borrow_q <= slice_bout;
               idx_q    <= idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(NSLICES - 1)) begin
                  // diff only changes here, so it keeps the last completed
                  // result while no result is being presented.
`ifdef SUB_SATURATE_EN
                  diff_q <= slice_bout ? '0 : res_d;
`else
                  diff_q <= res_d;
`endif
                  borrow_out_q <= slice_bout;
                  out_valid_q  <= 1'b1;
                  state_q      <= DONE;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end

            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_sub_32bit_seq.sv
// ---------------------------------------------------------------------------
// tb_sub_32bit_seq -- self-checking bench for sub_32bit_seq at default
// parameters. Expected results come from plain 32-bit arithmetic.
// ---------------------------------------------------------------------------
module tb_sub_32bit_seq;

   localparam int W   = 32;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  diff;
   logic          borrow_out;

   int total = 0;
   int bad   = 0;

   sub_32bit_seq #(
      .WIDTH   (32),
      .SLICE_W (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] ed;
      logic         eb;
      int           hold;
      bit           pulse;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Inputs applied before step() are seen at its rising edge; outputs are
   // sampled 1 time unit after that edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: unsigned subtract with optional floor saturation.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      logic         br;
      d  = x - y;
      br = (x < y);
`ifdef SUB_SATURATE_EN
      if (br) d = '0;
`endif
      return {br, d};
   endfunction

   task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [W-1:0] ed, input logic eb,
                         input int hold, input bit pulse);
      int lat;
      chk({nm, "/in_ready_before"}, 64'(in_ready), 64'd1);
      a         = ta;
      b         = tb_;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk({nm, "/in_ready_busy"}, 64'(in_ready), 64'd0);
      // Operands change after the accept edge and must not matter.
      a = $urandom;
      b = $urandom;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         if (out_valid) break;
         step();
         lat = i;
      end
      chk({nm, "/latency"}, 64'(lat), 64'(LAT));
      chk({nm, "/diff"}, 64'(diff), 64'(ed));
      chk({nm, "/borrow"}, 64'(borrow_out), 64'(eb));
      for (int h = 0; h < hold; h++) begin
         if (pulse && h == 1) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
         end
         step();
         in_valid = 1'b0;
         chk({nm, "/hold_valid"}, 64'(out_valid), 64'd1);
         chk({nm, "/hold_diff"}, 64'(diff), 64'(ed));
         chk({nm, "/hold_borrow"}, 64'(borrow_out), 64'(eb));
         chk({nm, "/hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      if (pulse) in_valid = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({nm, "/released_valid"}, 64'(out_valid), 64'd0);
      chk({nm, "/released_in_ready"}, 64'(in_ready), 64'd1);
      chk({nm, "/diff_kept"}, 64'(diff), 64'(ed));
   endtask

   vec_t vecs[$];

   initial begin
      logic [W:0] m;
      logic [W-1:0] ra, rb;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      step();
      step();
      chk("reset/in_ready", 64'(in_ready), 64'd1);
      chk("reset/out_valid", 64'(out_valid), 64'd0);
      chk("reset/diff", 64'(diff), 64'd0);
      chk("reset/borrow", 64'(borrow_out), 64'd0);
      rst_n = 1'b1;
      step();
      chk("post_reset/in_ready", 64'(in_ready), 64'd1);

      vecs.push_back('{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 0, 1'b0});
      vecs.push_back('{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1, 1'b0});
`ifdef SUB_SATURATE_EN
      vecs.push_back('{32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 0, 1'b0});
      vecs.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2, 1'b0});
`else
      vecs.push_back('{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 0, 1'b0});
      vecs.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 2, 1'b0});
`endif
      vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0});
      vecs.push_back('{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3, 1'b1});

      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
                vecs[i].ed, vecs[i].eb, vecs[i].hold, vecs[i].pulse);
         step();
      end

      // Reset during the second CALC cycle aborts the operation.
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort/in_ready", 64'(in_ready), 64'd1);
      chk("abort/out_valid", 64'(out_valid), 64'd0);
      chk("abort/diff", 64'(diff), 64'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            step();
         end
         chk("abort/no_result", 64'(seen), 64'd0);
      end
      run_op("after_abort", 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 0, 1'b0);

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = (i % 4 == 0) ? ra + 32'($urandom_range(0, 3)) : $urandom;
         m  = model(ra, rb);
         run_op($sformatf("rand%0d", i), ra, rb, m[W-1:0], m[W],
                int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
